jk_bank_by_t: RTL and testbench
===============================

Name: jk_bank_by_t

Overview:
- WIDTH-bit bank of JK-behaving flip-flops built from T-type storage cells. This is the JK-from-T conversion: T = (J & ~Q) | (K & Q) per bit.
- Commands are accepted through a valid/ready handshake.
- Keeps a saturating count of bit toggles and raises a change pulse.
- Serves as a reusable JK register bank for control/status logic that specifies set/reset/toggle per bit.

Parameters:
WIDTH, 8, number of JK bits in the bank
CNT_W, 16, width of the toggle-event counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  JK command present on j/k
cmd_ready  output  1  bank can accept a command this cycle
freeze  input  1  blocks command acceptance while high
j  input  WIDTH  per-bit J inputs
k  input  WIDTH  per-bit K inputs
q  output  WIDTH  bank state
qb  output  WIDTH  complement of q
tog_clr  input  1  clears toggle counter
tog_cnt  output  CNT_W  saturating count of bit toggles
changed  output  1  one-cycle pulse, previous accepted command altered q

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values, on the rst=1 edge:
  - q=0, qb=all ones
  - tog_cnt=0, changed=0
  - state=IDLE
- rst has priority over every other input.
- cmd_ready = (state==IDLE) & ~freeze. It is combinational from registered state and freeze.
- Accept = cmd_valid & cmd_ready.
- FSM states:
  - IDLE: on accept, apply the command at this edge and go to SETTLE.
  - SETTLE: one cycle with cmd_ready=0; return to IDLE. Maximum throughput is one command every 2 cycles.
- Apply, per bit i on accept:
  - t[i] = (j[i] & ~q[i]) | (k[i] & q[i])
  - q[i] <= q[i] ^ t[i]
- Resulting per-bit truth table:
  - J=0,K=0 hold
  - J=0,K=1 clear
  - J=1,K=0 set
  - J=1,K=1 toggle
- qb is always exactly ~q. It is never independently stored or toggled.
- Without accept, q holds. cmd_valid while not ready is ignored; the source must hold it.
- changed: registered; equals 1 on the cycle after an accept with t != 0, otherwise 0.
- tog_cnt:
  - On accept, adds popcount(t). The sum is computed at CNT_W+1 bits; if it exceeds 2^CNT_W-1, tog_cnt saturates at all ones.
  - tog_clr without accept: tog_cnt <= 0.
  - tog_clr with accept in the same cycle: tog_cnt <= popcount(t). Clear first, then add.
- freeze asserted in SETTLE has no effect beyond keeping cmd_ready low afterwards.
- rst mid-SETTLE: returns to IDLE with reset values; the pending changed pulse is dropped.

Optional Feature:
- Macro JK_BANK_PARITY_EN.
- When defined:
  - Adds output parity (1 bit), registered, equal to ^q. Reset value 0.
  - Updated in the same edge as q, so it is always consistent with q.
- When undefined: no parity port and no parity logic.

Decomposition:
- Shared package jk_bank_pkg:
  - state typedef (IDLE, SETTLE)
  - JK encoding constants: JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11
  - popcount function
- Sub-module t_cell: one T flip-flop with sync active-high reset. Ports clk, rst, en, t, q; q <= q ^ t when en.
- jk_bank_by_t instantiates WIDTH t_cells via generate. It holds the excitation logic, FSM, counter and change pulse.

Test Plan:
- Reset: rst=1 for 2 cycles -> q=8'h00, qb=8'hFF, tog_cnt=0, changed=0, cmd_ready=1 once rst=0 and freeze=0.
- Truth table: from q=0, accept j=8'hF0,k=8'h00 -> q=8'hF0, tog_cnt=4. Then accept j=8'h3C,k=8'h3C -> q=8'hCC, tog_cnt=8. Then accept j=0,k=8'h0F -> q=8'hC0, tog_cnt=10. qb=~q throughout; changed=1 one cycle after each accept.
- Hold/handshake: accept j=0,k=0 -> q unchanged, changed=0. With cmd_valid held high, cmd_ready alternates 1,0 and exactly every other cycle is accepted. freeze=1 -> cmd_ready=0 and q is stable over 5 valid cycles.
- Saturation/clear: CNT_W=4, issue toggles totalling 20 -> tog_cnt=15. tog_clr together with accept j=k=8'h03 -> tog_cnt=2.
- Reset mid-operation: assert rst in SETTLE -> next cycle q=0, state IDLE, changed=0, cmd_ready=1.
- JK_BANK_PARITY_EN: q sequence 8'h01, 8'h03, 8'h07 -> parity 1, 0, 1, aligned with q.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// Shared types, JK encodings and helpers for the JK-from-T register bank.
package jk_bank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Callers zero-extend their vector to 64 bits; banks wider than 64 are not supported.
    function automatic logic [7:0] popcount(input logic [63:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/jk_bank_by_t_t_cell.sv
// Single T-type storage cell: q flips when enabled with t=1.
module t_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic t,
    output logic q
);

    logic r_q;

    // Toggle storage with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (en) begin
            r_q <= r_q ^ t;
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/jk_bank_by_t.sv
// WIDTH-bit JK register bank built from T cells, with handshake, toggle counter and change pulse.
// Optional macro JK_BANK_PARITY_EN adds a registered parity output tracking ^q.
module jk_bank_by_t
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             freeze,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    input  logic             tog_clr,
    output logic [CNT_W-1:0] tog_cnt,
`ifdef JK_BANK_PARITY_EN
    output logic             parity,
`endif
    output logic             changed
);

    // Extra headroom so cnt + popcount never wraps before the saturation compare.
    localparam int SUM_W = CNT_W + 8;
    localparam logic [SUM_W-1:0] CNT_MAX = {{8{1'b0}}, {CNT_W{1'b1}}};

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic [WIDTH-1:0] w_t;
    logic [7:0]       w_pop;
    logic [SUM_W-1:0] w_base;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] r_tog_cnt;
    logic             r_changed;

    assign cmd_ready = (r_state == IDLE) & ~freeze;
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_t       = (j & ~q) | (k & q);
    assign w_pop     = popcount(64'(w_t));
    assign w_base    = tog_clr ? {SUM_W{1'b0}} : SUM_W'(r_tog_cnt);
    assign w_sum     = w_base + SUM_W'(w_pop);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        t_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  (w_accept),
            .t   (w_t[gi]),
            .q   (q[gi])
        );
    end

    assign qb = ~q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: every accept is followed by one non-ready SETTLE cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_accept ? SETTLE : IDLE;
            SETTLE:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Saturating toggle counter; clear applies before the same-cycle add
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tog_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_tog_cnt <= (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end else if (tog_clr) begin
            r_tog_cnt <= {CNT_W{1'b0}};
        end else begin
            r_tog_cnt <= r_tog_cnt;
        end
    end

    // Change pulse for accepted commands that flipped at least one bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_accept & (|w_t);
        end
    end

    assign tog_cnt = r_tog_cnt;
    assign changed = r_changed;

`ifdef JK_BANK_PARITY_EN
    logic r_parity;

    // Parity of the next q, so it lands on the same edge as q
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^(q ^ w_t);
        end else begin
            r_parity <= r_parity;
        end
    end

    assign parity = r_parity;
`endif

endmodule

// File: tb/tb_jk_bank_by_t.sv
// Scoreboard bench for jk_bank_by_t; a CNT_W=4 copy shares the inputs for saturation checks.
module tb_jk_bank_by_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        freeze = 1'b0;
    logic        tog_clr = 1'b0;
    logic [7:0]  j = 8'h00;
    logic [7:0]  k = 8'h00;
    logic        cmd_ready, changed;
    logic [7:0]  q, qb;
    logic [15:0] tog_cnt;
    logic        cmd_ready4, changed4;
    logic [7:0]  q4, qb4;
    logic [3:0]  tog_cnt4;
`ifdef JK_BANK_PARITY_EN
    logic        parity, parity4;
`endif

    always #5 clk = ~clk;

    jk_bank_by_t #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .freeze(freeze), .j(j), .k(k), .q(q), .qb(qb), .tog_clr(tog_clr),
        .tog_cnt(tog_cnt),
`ifdef JK_BANK_PARITY_EN
        .parity(parity),
`endif
        .changed(changed)
    );

    jk_bank_by_t #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .freeze(freeze), .j(j), .k(k), .q(q4), .qb(qb4), .tog_clr(tog_clr),
        .tog_cnt(tog_cnt4),
`ifdef JK_BANK_PARITY_EN
        .parity(parity4),
`endif
        .changed(changed4)
    );

    typedef struct {
        logic [7:0]  q;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
        logic        chg;
        logic        par;
        logic        rdy;
        logic        rdy_chk;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_err = 0;
    logic obs_rdy;

    // reference model state
    logic [7:0] m_q = 8'h00;
    int         m_cnt = 0;
    int         m_cnt4 = 0;
    logic       m_idle = 1'b1;
    logic       m_par = 1'b0;
    logic       m_known = 1'b0;

    // Drive one cycle, update the model, push the expected post-edge state.
    task automatic drive(input logic r, input logic v, input logic frz, input logic clr,
                         input logic [7:0] jj, input logic [7:0] kk);
        exp_t       x;
        logic [7:0] t;
        logic       acc;
        int         c;
        rst = r; cmd_valid = v; freeze = frz; tog_clr = clr; j = jj; k = kk;
        #1;
        obs_rdy   = cmd_ready;
        x.rdy     = m_idle & ~frz;
        x.rdy_chk = m_known;
        acc       = v & x.rdy;
        if (r) begin
            m_q = 8'h00; m_cnt = 0; m_cnt4 = 0; m_idle = 1'b1; m_par = 1'b0;
            m_known = 1'b1; x.chg = 1'b0;
        end else begin
            t = (jj & ~m_q) | (kk & m_q);
            x.chg = acc && (t != 8'h00);
            if (acc) begin
                m_q = m_q ^ t;
                m_par = ^m_q;
                c = (clr ? 0 : m_cnt) + $countones(t);
                m_cnt = (c > 65535) ? 65535 : c;
                c = (clr ? 0 : m_cnt4) + $countones(t);
                m_cnt4 = (c > 15) ? 15 : c;
                m_idle = 1'b0;
            end else begin
                if (clr) begin
                    m_cnt = 0; m_cnt4 = 0;
                end
                m_idle = 1'b1;
            end
        end
        x.q = m_q; x.cnt = 16'(m_cnt); x.cnt4 = 4'(m_cnt4); x.par = m_par;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            e = sb.pop_front();
            n_chk++;
            if ({q, qb} !== {e.q, ~e.q}) begin
                n_err++; $display("FAIL reset q/qb act=%h/%h exp=%h/%h", q, qb, e.q, ~e.q);
            end
            n_chk++;
            if ({tog_cnt, changed} !== {e.cnt, e.chg}) begin
                n_err++; $display("FAIL reset cnt/chg act=%0d/%b exp=%0d/%b", tog_cnt, changed, e.cnt, e.chg);
            end
            if (e.rdy_chk) begin
                n_chk++;
                if (obs_rdy !== e.rdy) begin
                    n_err++; $display("FAIL reset ready act=%b exp=%b", obs_rdy, e.rdy);
                end
            end
        end
    endtask

    task automatic test_truth_table();
        logic [7:0] tj[6] = '{8'hF0, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00};
        logic [7:0] tk[6] = '{8'h00, 8'h00, 8'h3C, 8'h00, 8'h0F, 8'h00};
        logic       tv[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, tv[i], 1'b0, 1'b0, tj[i], tk[i]);
            e = sb.pop_front();
            n_chk++;
            if ({q, qb} !== {e.q, ~e.q}) begin
                n_err++; $display("FAIL truth q/qb step %0d act=%h/%h exp=%h/%h", i, q, qb, e.q, ~e.q);
            end
            n_chk++;
            if ({tog_cnt, changed} !== {e.cnt, e.chg}) begin
                n_err++; $display("FAIL truth cnt/chg step %0d act=%0d/%b exp=%0d/%b", i, tog_cnt, changed, e.cnt, e.chg);
            end
            n_chk++;
            if (obs_rdy !== e.rdy) begin
                n_err++; $display("FAIL truth ready step %0d act=%b exp=%b", i, obs_rdy, e.rdy);
            end
        end
        n_chk++;
        if (q !== 8'hC0 || tog_cnt !== 16'd10) begin
            n_err++; $display("FAIL truth final act=%h/%0d exp=c0/10", q, tog_cnt);
        end
    endtask

    task automatic test_hold_handshake();
        int nacc = 0;
        for (int i = 0; i < 13; i++) begin
            if (i == 0)      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
            else if (i == 1) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            else if (i < 8)  drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01);
            else             drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
            if (i >= 2 && i < 8 && e.rdy) nacc++;
            e = sb.pop_front();
            n_chk++;
            if ({q, qb} !== {e.q, ~e.q}) begin
                n_err++; $display("FAIL hold q/qb step %0d act=%h/%h exp=%h/%h", i, q, qb, e.q, ~e.q);
            end
            n_chk++;
            if ({tog_cnt, changed} !== {e.cnt, e.chg}) begin
                n_err++; $display("FAIL hold cnt/chg step %0d act=%0d/%b exp=%0d/%b", i, tog_cnt, changed, e.cnt, e.chg);
            end
            n_chk++;
            if (obs_rdy !== e.rdy) begin
                n_err++; $display("FAIL hold ready step %0d act=%b exp=%b", i, obs_rdy, e.rdy);
            end
        end
        n_chk++;
        if (q !== 8'hC1) begin
            n_err++; $display("FAIL hold frozen q act=%h exp=c1", q);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] tj[8] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h0F, 8'h00, 8'h03};
        logic       tv[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       tc[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, tv[i], 1'b0, tc[i], tj[i], tj[i]);
            e = sb.pop_front();
            n_chk++;
            if ({tog_cnt, tog_cnt4} !== {e.cnt, e.cnt4}) begin
                n_err++; $display("FAIL sat cnt step %0d act=%0d/%0d exp=%0d/%0d", i, tog_cnt, tog_cnt4, e.cnt, e.cnt4);
            end
            n_chk++;
            if ({q, qb, changed} !== {e.q, ~e.q, e.chg}) begin
                n_err++; $display("FAIL sat q/chg step %0d act=%h/%b exp=%h/%b", i, q, changed, e.q, e.chg);
            end
            if (i == 6) begin
                n_chk++;
                if (tog_cnt !== 16'd20 || tog_cnt4 !== 4'd15) begin
                    n_err++; $display("FAIL sat total act=%0d/%0d exp=20/15", tog_cnt, tog_cnt4);
                end
            end
        end
        n_chk++;
        if (tog_cnt !== 16'd2 || tog_cnt4 !== 4'd2) begin
            n_err++; $display("FAIL sat clr+add act=%0d/%0d exp=2/2", tog_cnt, tog_cnt4);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00);
            else if (i == 1) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            else             drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            e = sb.pop_front();
            n_chk++;
            if ({q, qb} !== {e.q, ~e.q}) begin
                n_err++; $display("FAIL rstmid q/qb step %0d act=%h/%h exp=%h/%h", i, q, qb, e.q, ~e.q);
            end
            n_chk++;
            if ({tog_cnt, changed} !== {e.cnt, e.chg}) begin
                n_err++; $display("FAIL rstmid cnt/chg step %0d act=%0d/%b exp=%0d/%b", i, tog_cnt, changed, e.cnt, e.chg);
            end
            n_chk++;
            if (obs_rdy !== e.rdy) begin
                n_err++; $display("FAIL rstmid ready step %0d act=%b exp=%b", i, obs_rdy, e.rdy);
            end
        end
    endtask

`ifdef JK_BANK_PARITY_EN
    task automatic test_parity();
        logic [7:0] tj[6] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00};
        logic [7:0] tk[6] = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       tv[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, tv[i], 1'b0, 1'b0, tj[i], tk[i]);
            e = sb.pop_front();
            n_chk++;
            if ({q, parity} !== {e.q, e.par}) begin
                n_err++; $display("FAIL parity step %0d act=%h/%b exp=%h/%b", i, q, parity, e.q, e.par);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_truth_table();
        test_hold_handshake();
        test_saturation();
        test_reset_mid();
`ifdef JK_BANK_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
